apb_modport: RTL and testbench



---
 rtl/apb_modport_if.sv | 40 ++++
 rtl/apb_modport.sv | 129 ++++++++++++
 tb/tb_apb_modport.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/apb_modport_if.sv
// ---------------------------------------------------------------------------
// apb_modport_if
// Transfer-request interface into the APB two-slave subsystem.
//   transfer          : request a transaction
//   read_write        : 1 = read, 0 = write
//   apb_write_paddr   : write address (AW bits, MSB selects slave)
//   apb_read_paddr    : read address  (AW bits, MSB selects slave)
//   apb_write_data    : write data (DW bits)
//   apb_read_data_out : registered data of the last completed read
// Modports: master = requester side, slave = the subsystem.
// ---------------------------------------------------------------------------
interface apb_modport_if #(
    parameter int AW = 9,
    parameter int DW = 8
);
    logic          transfer;
    logic          read_write;
    logic [AW-1:0] apb_write_paddr;
    logic [AW-1:0] apb_read_paddr;
    logic [DW-1:0] apb_write_data;
    logic [DW-1:0] apb_read_data_out;

    modport master (
        output transfer,
        output read_write,
        output apb_write_paddr,
        output apb_read_paddr,
        output apb_write_data,
        input  apb_read_data_out
    );

    modport slave (
        input  transfer,
        input  read_write,
        input  apb_write_paddr,
        input  apb_read_paddr,
        input  apb_write_data,
        output apb_read_data_out
    );
endinterface

// File: rtl/apb_modport.sv
// ---------------------------------------------------------------------------
// apb_modport
// APB master FSM (IDLE/SETUP/ACCESS) driving two zero-wait APB memory
// slaves on an internal bus. Address bit AW-1 selects the slave, bits
// AW-2:0 index its memory (2**(AW-1) words each).
// Ports:
//   pclk    : clock, all state on rising edge
//   presetn : asynchronous active-low reset (clears FSM, bus and memories)
//   bus     : apb_modport_if.slave (transfer request in, read data out)
// ---------------------------------------------------------------------------
module apb_modport #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic         pclk,
    input  logic         presetn,
    apb_modport_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** (AW - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t        state;
    logic          psel1;
    logic          psel2;
    logic          penable;
    logic          pwrite;
    logic          pready;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic [DW-1:0] prdata1;
    logic [DW-1:0] prdata2;
    logic [DW-1:0] rdata_q;
    logic [AW-1:0] req_paddr;
    logic [AW-2:0] idx;
    logic          accept;

    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] mem2 [DEPTH];

    // Zero-wait slaves.
    assign pready    = 1'b1;
    assign idx       = paddr[AW-2:0];
    assign req_paddr = bus.read_write ? bus.apb_read_paddr : bus.apb_write_paddr;
    assign bus.apb_read_data_out = rdata_q;

    // A new request is only taken in IDLE or on the completing ACCESS edge.
    always_comb begin
        accept = 1'b0;
        if (bus.transfer && (state == IDLE || (state == ACCESS && pready)))
            accept = 1'b1;
    end

    // Master FSM with registered bus outputs.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state   <= IDLE;
            psel1   <= 1'b0;
            psel2   <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    psel1   <= 1'b0;
                    psel2   <= 1'b0;
                    penable <= 1'b0;
                end
                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                end
                ACCESS: begin
                    if (pready) begin
                        if (!pwrite)
                            rdata_q <= prdata;
                        state   <= IDLE;
                        psel1   <= 1'b0;
                        psel2   <= 1'b0;
                        penable <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // Latching here overrides the IDLE/ACCESS defaults above so a
            // back-to-back request goes straight to SETUP.
            if (accept) begin
                state   <= SETUP;
                pwrite  <= ~bus.read_write;
                paddr   <= req_paddr;
                pwdata  <= bus.apb_write_data;
                psel1   <= ~req_paddr[AW-1];
                psel2   <= req_paddr[AW-1];
                penable <= 1'b0;
            end
        end
    end

    // Slave 1 memory.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem1[i] <= '0;
        end else if (psel1 && penable && pready && pwrite) begin
            mem1[idx] <= pwdata;
        end
    end

    // Slave 2 memory.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem2[i] <= '0;
        end else if (psel2 && penable && pready && pwrite) begin
            mem2[idx] <= pwdata;
        end
    end

    // Each slave drives PRDATA only when selected; mux by address MSB.
    assign prdata1 = psel1 ? mem1[idx] : '0;
    assign prdata2 = psel2 ? mem2[idx] : '0;
    assign prdata  = paddr[AW-1] ? prdata2 : prdata1;

endmodule

// File: tb/tb_apb_modport.sv
// ---------------------------------------------------------------------------
// tb_apb_modport
// Directed stimulus for apb_modport. Each issued transfer pushes the
// expected apb_read_data_out value and the cycle it must be visible at into
// a scoreboard queue; a negedge monitor pops and compares on that cycle.
// ---------------------------------------------------------------------------
module tb_apb_modport;
    localparam int AW = 9;
    localparam int DW = 8;

    logic pclk = 1'b0;
    logic presetn;

    always #5 pclk = ~pclk;

    apb_modport_if #(.AW(AW), .DW(DW)) bus ();

    apb_modport #(.AW(AW), .DW(DW)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [7:0]  exp;
        string       name;
    } sb_t;

    sb_t  sbq[$];
    int   n_pass  = 0;
    int   n_total = 0;
    logic [7:0] exp_rdata  = 8'h00;
    logic       track_hold = 1'b1;

    task automatic expect_at(input int due, input logic [7:0] exp, input string name);
        sb_t e;
        e.due  = due;
        e.exp  = exp;
        e.name = name;
        sbq.push_back(e);
    endtask

    // Monitor: compare every entry due on the current cycle.
    always @(negedge pclk) begin
        sb_t e;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            n_total++;
            if (e.due != cyc)
                $display("FAIL %s: check slot missed, due cycle %0d now %0d", e.name, e.due, cyc);
            else if (bus.apb_read_data_out !== e.exp)
                $display("FAIL %s: apb_read_data_out=%02h expected %02h (cycle %0d)",
                         e.name, bus.apb_read_data_out, e.exp, cyc);
            else
                n_pass++;
        end
    end

    task automatic idle(input int n);
        bus.transfer = 1'b0;
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    // Present one request, wait for the accepting edge (E0) and the SETUP
    // edge (E1); returns during ACCESS so a following call is back-to-back.
    // Request inputs are scrambled during SETUP to prove they are ignored.
    task automatic xfer(input logic rd, input logic [AW-1:0] addr, input logic [7:0] wdata,
                        input logic [7:0] exp, input string name, input logic hold);
        bus.transfer       = 1'b1;
        bus.read_write     = rd;
        bus.apb_read_paddr  = rd ? addr : ~addr;
        bus.apb_write_paddr = rd ? ~addr : addr;
        bus.apb_write_data = wdata;
        @(posedge pclk);
        #1;
        if (rd) begin
            exp_rdata = exp;
            expect_at(cyc + 2, exp, name);
        end else if (track_hold) begin
            expect_at(cyc + 2, exp_rdata, name);
        end
        bus.transfer        = hold;
        bus.read_write      = ~rd;
        bus.apb_read_paddr  = ~bus.apb_read_paddr;
        bus.apb_write_paddr = ~bus.apb_write_paddr;
        bus.apb_write_data  = 8'hFF;
        @(posedge pclk);
        #1;
    endtask

    initial begin
        presetn             = 1'b1;
        bus.transfer        = 1'b0;
        bus.read_write      = 1'b0;
        bus.apb_write_paddr = '0;
        bus.apb_read_paddr  = '0;
        bus.apb_write_data  = '0;
        #2 presetn = 1'b0;
        @(posedge pclk);
        #1;
        expect_at(cyc, 8'h00, "reset_rdata");
        @(posedge pclk);
        #1;
        presetn = 1'b1;
        idle(1);

        // Never-written location reads as zero.
        xfer(1'b1, 9'h0AB, 8'h00, 8'h00, "rd_unwritten", 1'b0);
        idle(1);

        // Slave 1 write then read.
        xfer(1'b0, 9'h012, 8'hA5, 8'h00, "wr_012_hold", 1'b0);
        idle(1);
        xfer(1'b1, 9'h012, 8'h00, 8'hA5, "rd_012_a5", 1'b0);
        idle(2);
        expect_at(cyc, 8'hA5, "idle_hold_a5");
        idle(1);

        // Slave 2 isolation.
        xfer(1'b0, 9'h112, 8'h3C, 8'h00, "wr_112_hold", 1'b0);
        idle(1);
        xfer(1'b0, 9'h012, 8'h77, 8'h00, "wr_012_hold", 1'b0);
        idle(1);
        xfer(1'b1, 9'h112, 8'h00, 8'h3C, "rd_112_3c", 1'b0);
        idle(1);
        xfer(1'b1, 9'h012, 8'h00, 8'h77, "rd_012_77", 1'b0);
        idle(1);

        // Back-to-back: four writes then four reads, transfer held high.
        for (int i = 0; i < 4; i++)
            xfer(1'b0, 9'(i), 8'(8'h10 + i), 8'h00, "b2b_wr_hold", 1'b1);
        for (int i = 0; i < 4; i++)
            xfer(1'b1, 9'(i), 8'h00, 8'(8'h10 + i), $sformatf("b2b_rd_%0d", i), i < 3);
        idle(1);

        // Write data changes during SETUP must not be captured.
        xfer(1'b0, 9'h020, 8'h55, 8'h00, "wr_020_hold", 1'b0);
        idle(1);
        xfer(1'b1, 9'h020, 8'h00, 8'h55, "rd_020_55", 1'b0);
        idle(1);

        // Top index of each slave; read data holds across a write.
        xfer(1'b0, 9'h0FF, 8'hEE, 8'h00, "wr_0ff_hold", 1'b0);
        xfer(1'b0, 9'h1FF, 8'hDD, 8'h00, "wr_1ff_hold", 1'b0);
        idle(1);
        xfer(1'b1, 9'h0FF, 8'h00, 8'hEE, "rd_0ff_ee", 1'b0);
        idle(1);
        xfer(1'b0, 9'h030, 8'h42, 8'h00, "wr_030_hold_ee", 1'b0);
        idle(1);
        xfer(1'b1, 9'h1FF, 8'h00, 8'hDD, "rd_1ff_dd", 1'b0);
        idle(1);

        // Reset during ACCESS of a write aborts it and clears everything.
        track_hold = 1'b0;
        xfer(1'b0, 9'h005, 8'h99, 8'h00, "wr_005_abort", 1'b0);
        presetn = 1'b0;
        exp_rdata = 8'h00;
        expect_at(cyc, 8'h00, "rst_mid_rdata");
        expect_at(cyc + 1, 8'h00, "rst_mid_rdata_hold");
        @(posedge pclk);
        #1;
        @(posedge pclk);
        #1;
        presetn = 1'b1;
        track_hold = 1'b1;
        idle(1);
        xfer(1'b1, 9'h005, 8'h00, 8'h00, "rd_005_after_rst", 1'b0);
        idle(1);
        xfer(1'b1, 9'h1FF, 8'h00, 8'h00, "rd_1ff_cleared", 1'b0);
        idle(1);
        xfer(1'b1, 9'h012, 8'h00, 8'h00, "rd_012_cleared", 1'b0);
        idle(4);

        while (sbq.size() > 0) begin
            sb_t e;
            e = sbq.pop_front();
            n_total++;
            $display("FAIL %s: never checked, due cycle %0d expected %02h", e.name, e.due, e.exp);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
